// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the LEGv8 memory-access stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_access_stage_pkg;

    // Datapath width of the LEGv8 core.
    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Doubleword accesses must be 8-byte aligned.
    localparam logic [2:0] MEM_ALIGN_MASK = 3'b111;

    function automatic logic addr_misaligned(input logic [2:0] addr_lsb);
        return (addr_lsb & MEM_ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// MEM stage: resolves branches, runs LDUR/STUR over a req/gnt/rvalid port, registers MEM/WB.
// Latency: non-memory 1 cycle; memory accept+1 (REQ) + gnt wait + rvalid wait + 1 (DONE).
// Backpressure: ex_ready low from accept of an aligned memory op until the cycle after DONE.
// Ports: clk/reset (sync, active high); ex_* execute handshake and operands; pc_src/pc_target
//        branch redirect pulse; dmem_* data-memory handshake; wb_* registered MEM/WB bundle; fault.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD    = WORD_W,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic            zero,
    input  logic [WORD-1:0] branch_target,
    input  logic [WORD-1:0] read_data2,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    input  logic [4:0]      write_reg,
    output logic            pc_src,
    output logic [WORD-1:0] pc_target,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [WORD-1:0] dmem_addr,
    output logic [WORD-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [WORD-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [4:0]      wb_write_reg,
    output logic [WORD-1:0] wb_alu_result,
    output logic [WORD-1:0] wb_read_data,
    output logic            fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    logic accept;
    logic is_mem;
    logic misaligned;
    logic take_branch;

    assign ex_ready    = (state == IDLE);
    assign accept      = ex_valid & ex_ready;
    assign is_mem      = mem_read | mem_write;
    assign misaligned  = is_mem & addr_misaligned(alu_result[2:0]);
    assign take_branch = (branch & zero) | uncond_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            pc_src        <= 1'b0;
            pc_target     <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_write_reg  <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            fault         <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            pc_src   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // The WB bundle is captured at accept and held for the whole
                        // access; only wb_valid marks when it is meaningful.
                        wb_reg_write  <= reg_write;
                        wb_mem_to_reg <= mem_to_reg;
                        wb_write_reg  <= write_reg;
                        wb_alu_result <= alu_result;
                        wb_read_data  <= '0;
                        if (take_branch) begin
                            pc_src    <= 1'b1;
                            pc_target <= branch_target;
                        end
                        if (is_mem && !misaligned) begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= alu_result;
                            dmem_wdata <= read_data2;
                        end else begin
                            // Non-memory ops and misaligned accesses retire next cycle.
                            wb_valid <= 1'b1;
                            if (misaligned) begin
                                fault        <= 1'b1;
                                wb_reg_write <= 1'b0;
                            end
                        end
                    end
                end

                REQ: begin
                    // Address/data/we stay put until the memory grants.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        wait_cnt <= '0;
                        if (dmem_we) begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                        end else if (dmem_rvalid) begin
                            // Zero-latency memory: data arrives with the grant.
                            wb_read_data <= dmem_rdata;
                            state        <= DONE;
                            wb_valid     <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // Data wins over timeout if both happen in the last allowed cycle.
                    if (dmem_rvalid) begin
                        wb_read_data <= dmem_rdata;
                        state        <= DONE;
                        wb_valid     <= 1'b1;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state        <= DONE;
                        wb_valid     <= 1'b1;
                        fault        <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized instruction stream plus directed cases.
// Latency: expected wb_valid/pc_src arrival times derived from handshake delays chosen by the driver.
// Backpressure: the driver waits on ex_ready (bounded) before each issue.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int W       = 64;
    localparam int TIMEOUT = 16;
    localparam int NO_DATA = 99;   // rvalid delay meaning "withhold data"

    logic         clk, reset;
    logic         ex_valid, ex_ready;
    logic [W-1:0] alu_result, branch_target, read_data2;
    logic         zero, mem_read, mem_write, branch, uncond_branch;
    logic         reg_write, mem_to_reg;
    logic [4:0]   write_reg;
    logic         pc_src;
    logic [W-1:0] pc_target;
    logic         dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic         wb_valid, wb_reg_write, wb_mem_to_reg, fault;
    logic [4:0]   wb_write_reg;
    logic [W-1:0] wb_alu_result, wb_read_data;

    mem_access_stage #(.WORD(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .read_data2(read_data2), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .uncond_branch(uncond_branch), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .write_reg(write_reg),
        .pc_src(pc_src), .pc_target(pc_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result),
        .wb_read_data(wb_read_data), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        time          t;
        logic         rw;
        logic         m2r;
        logic [4:0]   wr;
        logic [W-1:0] alu;
        logic [W-1:0] rd;
        logic         chk_rd;
        logic         flt;
    } wb_exp_t;

    typedef struct {
        time          t;
        logic [W-1:0] tgt;
    } pc_exp_t;

    wb_exp_t wb_q[$];
    pc_exp_t pc_q[$];
    wb_exp_t me;
    pc_exp_t mp;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compares every wb_valid / pc_src pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_valid_unexpected", wb_valid, 1'b0);
                end else begin
                    me = wb_q.pop_front();
                    chk("wb_time", $time, me.t);
                    chk("wb_reg_write", wb_reg_write, me.rw);
                    chk("wb_mem_to_reg", wb_mem_to_reg, me.m2r);
                    chk("wb_write_reg", wb_write_reg, me.wr);
                    chk("wb_alu_result", wb_alu_result, me.alu);
                    chk("fault", fault, me.flt);
                    if (me.chk_rd) chk("wb_read_data", wb_read_data, me.rd);
                end
            end else begin
                if (wb_q.size() != 0 && wb_q[0].t <= $time) begin
                    chk("wb_valid_missing", wb_valid, 1'b1);
                    void'(wb_q.pop_front());
                end
                if (fault) chk("fault_without_wb", fault, 1'b0);
            end
            if (pc_src) begin
                if (pc_q.size() == 0) begin
                    chk("pc_src_unexpected", pc_src, 1'b0);
                end else begin
                    mp = pc_q.pop_front();
                    chk("pc_time", $time, mp.t);
                    chk("pc_target", pc_target, mp.tgt);
                end
            end else if (pc_q.size() != 0 && pc_q[0].t <= $time) begin
                chk("pc_src_missing", pc_src, 1'b1);
                void'(pc_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 60; k++) begin
            if (ex_ready) return;
            @(posedge clk); #1;
        end
        chk("ex_ready_timeout", ex_ready, 1'b1);
    endtask

    // Issue one instruction. g = REQ cycles before gnt; r = cycles from gnt to rvalid
    // (0 = with gnt, > TIMEOUT = never).
    task automatic issue(input logic mr, input logic mw, input logic br, input logic ub,
                         input logic z, input logic rw, input logic m2r, input logic [4:0] wr,
                         input logic [W-1:0] alu, input logic [W-1:0] tgt, input logic [W-1:0] rd2,
                         input int g, input int r, input logic [W-1:0] rdat);
        time     ta;
        int      d;
        logic    mis, ld, mem, flt;
        wb_exp_t e;
        wait_ready();
        // Idle cycles with stray rvalid, which IDLE must ignore.
        repeat ($urandom_range(0, 2)) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        dmem_rvalid   = 1'b0;
        mem_read      = mr;  mem_write  = mw;  branch    = br; uncond_branch = ub;
        zero          = z;   reg_write  = rw;  mem_to_reg = m2r; write_reg = wr;
        alu_result    = alu; branch_target = tgt; read_data2 = rd2;
        ex_valid      = 1'b1;
        @(posedge clk);
        ta = $time;
        #1 ex_valid = 1'b0;

        mem = mr | mw;
        mis = mem && (alu % 8 != 0);
        ld  = mr && !mw;
        if (!mem || mis)                d = 0;
        else if (!ld || r == 0)         d = g + 1;
        else if (r <= TIMEOUT)          d = g + 1 + r;
        else                            d = g + 1 + TIMEOUT;
        flt      = mis || (ld && r > TIMEOUT);
        e.t      = ta + 10 * d + 5;
        e.rw     = flt ? 1'b0 : rw;
        e.m2r    = m2r;
        e.wr     = wr;
        e.alu    = alu;
        e.rd     = rdat;
        e.chk_rd = ld && !mis && r <= TIMEOUT;
        e.flt    = flt;
        wb_q.push_back(e);
        if ((br && z) || ub) pc_q.push_back('{ta + 5, tgt});

        if (mem && !mis) begin
            for (int i = 0; i <= g; i++) begin
                chk("dmem_req", dmem_req, 1'b1);
                chk("dmem_addr", dmem_addr, alu);
                chk("dmem_we", dmem_we, mw);
                if (mw) chk("dmem_wdata", dmem_wdata, rd2);
                chk("ex_ready_stall", ex_ready, 1'b0);
                if (i < g) begin
                    dmem_gnt    = 1'b0;
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata  = {$urandom, $urandom};
                end else begin
                    dmem_gnt    = 1'b1;
                    dmem_rvalid = ld && r == 0;
                    dmem_rdata  = rdat;
                end
                @(posedge clk); #1;
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            chk("dmem_req_drop", dmem_req, 1'b0);
            if (ld && r >= 1 && r <= TIMEOUT) begin
                repeat (r - 1) begin @(posedge clk); #1; end
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdat;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
            end
        end else if (!mem) begin
            chk("ex_ready_nonmem", ex_ready, 1'b1);
        end else begin
            chk("no_req_misaligned", dmem_req, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, t, d2, rd;
        logic [4:0]   wr;
        logic         z, rw;
        int           k, g, r;

        reset = 1'b1; ex_valid = 1'b0; alu_result = '0; branch_target = '0; read_data2 = '0;
        zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; uncond_branch = 1'b0;
        reg_write = 1'b0; mem_to_reg = 1'b0; write_reg = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_pc_src", pc_src, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 64'd0);
        chk("rst_wb_alu_result", wb_alu_result, 64'd0);
        reset = 1'b0;

        // Directed cases.
        issue(0, 0, 0, 0, 0, 1, 0, 5'd10, 64'd30, 64'd0, 64'd0, 0, 0, 64'd0);            // ADD
        issue(1, 0, 0, 0, 0, 1, 1, 5'd5, 64'd80, 64'd0, 64'd0, 1, 3, 64'h1234);          // LDUR
        issue(0, 1, 0, 0, 0, 0, 0, 5'd0, 64'd112, 64'd0, 64'hDEAD, 2, 0, 64'd0);         // STUR
        issue(0, 0, 1, 0, 1, 0, 0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0, 64'd0);
        issue(0, 0, 1, 0, 0, 0, 0, 5'd0, 64'd1, 64'd100, 64'd0, 0, 0, 64'd0);            // CBZ not taken
        issue(0, 0, 0, 1, 0, 0, 0, 5'd0, 64'd7, 64'd280, 64'd0, 0, 0, 64'd0);            // B
        issue(1, 0, 0, 0, 0, 1, 1, 5'd3, 64'd81, 64'd0, 64'd0, 0, 0, 64'd0);             // misaligned
        issue(1, 0, 0, 0, 0, 1, 1, 5'd4, 64'd88, 64'd0, 64'd0, 0, NO_DATA, 64'd0);       // timeout
        issue(1, 0, 0, 0, 0, 1, 1, 5'd6, 64'd96, 64'd0, 64'd0, 0, TIMEOUT, 64'hBEEF);    // last-cycle data
        issue(1, 0, 0, 0, 0, 1, 1, 5'd7, 64'd104, 64'd0, 64'd0, 2, 0, 64'h5A5A);         // rvalid with gnt

        // Randomized stream.
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 4);
            a  = {$urandom, $urandom} & ~64'h7;
            if (k <= 2 && k >= 1 && $urandom_range(0, 5) == 0) a = a | 64'($urandom_range(1, 7));
            t  = {$urandom, $urandom};
            d2 = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            wr = 5'($urandom_range(0, 31));
            z  = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            g  = $urandom_range(0, 3);
            r  = $urandom_range(0, 20);
            case (k)
                0: issue(0, 0, 0, 0, z, rw, 0, wr, a, t, d2, 0, 0, rd);
                1: issue(1, 0, 0, 0, z, 1, 1, wr, a, t, d2, g, r, rd);
                2: issue(0, 1, 0, 0, z, 0, 0, wr, a, t, d2, g, 0, rd);
                3: issue(0, 0, 1, 0, z, 0, 0, wr, a, t, d2, 0, 0, rd);
                default: issue(0, 0, 0, 1, z, 0, 0, wr, a, t, d2, 0, 0, rd);
            endcase
        end

        // Reset while a load sits in WAIT: the access is dropped and late data is ignored.
        wait_ready();
        repeat (3) begin @(posedge clk); #1; end
        mem_read = 1'b1; mem_write = 1'b0; branch = 1'b0; uncond_branch = 1'b0;
        alu_result = 64'd200; reg_write = 1'b1; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid_dmem_req", dmem_req, 1'b0);
        chk("rstmid_ex_ready", ex_ready, 1'b1);
        chk("rstmid_wb_valid", wb_valid, 1'b0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hBAD;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("late_rvalid_wb_valid", wb_valid, 1'b0);
        end
        #1;
        // Timeout counter must start fresh after the reset.
        issue(1, 0, 0, 0, 0, 1, 1, 5'd9, 64'd208, 64'd0, 64'd0, 0, TIMEOUT, 64'hC0FFEE);
        issue(1, 0, 0, 0, 0, 1, 1, 5'd9, 64'd216, 64'd0, 64'd0, 1, NO_DATA, 64'd0);

        wait_ready();
        repeat (5) @(posedge clk);
        #1;
        chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        chk("pc_queue_drained", 64'(pc_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
